// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the memory access controller: FSM state encoding,
// REQ_SIZE encodings, the default memory depth and the alignment check used
// when a request is accepted.
// No ports (package).
// -----------------------------------------------------------------------------
package mem_pkg;

  localparam int MEM_WORDS_DEFAULT = 512;

  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_RESP  = 3'd3,
    ST_DUMP  = 3'd4
  } state_t;

  // True when the access size cannot be served at this byte offset.
  // The illegal size encoding is folded in here so one test covers both.
  function automatic logic size_addr_bad(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = addr_lo[0];
      SIZE_WORD: bad = (addr_lo != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align
// Combinational little-endian lane handling for sub-word accesses.
//   rd_word     in  32  word read from memory
//   addr_lo     in  2   byte offset within the word
//   size        in  2   access size (mem_pkg SIZE_*)
//   unsigned_ld in  1   1 = zero-extend loads, 0 = sign-extend
//   wdata       in  32  right-aligned store data
//   load_data   out 32  extracted and extended load result
//   merged_word out 32  rd_word with the addressed lane replaced by wdata
// -----------------------------------------------------------------------------
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rd_word[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];

    case (size)
      SIZE_BYTE: load_data = unsigned_ld ? {24'd0, byte_sel}
                                         : {{24{byte_sel[7]}}, byte_sel};
      SIZE_HALF: load_data = unsigned_ld ? {16'd0, half_sel}
                                         : {{16{half_sel[15]}}, half_sel};
      default:   load_data = rd_word;
    endcase
  end

  always_comb begin
    merged_word = rd_word;
    case (size)
      SIZE_BYTE: merged_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      SIZE_HALF: begin
        if (addr_lo[1]) merged_word[31:16] = wdata[15:0];
        else            merged_word[15:0]  = wdata[15:0];
      end
      SIZE_WORD: merged_word = wdata;
      default:   merged_word = rd_word;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
// Load/store front end between a core and a word-wide main memory. Handles
// byte/half/word accesses, sign/zero extension, read-modify-write for sub-word
// stores, error detection and a one-shot memory dump trigger.
//
// Ports
//   CLK, RESET (async, active-high)
//   REQ_VALID/REQ_READY handshake; REQ_WE, REQ_SIZE, REQ_UNSIGNED, REQ_ADDR,
//   REQ_WDATA request fields (registered on acceptance)
//   RSP_VALID (one-cycle pulse), RSP_RDATA, RSP_ERR
//   MEM_READ_EN/MEM_READ_ADDRESS/MEM_READ_DATA (combinational read)
//   MEM_WRITE_EN/MEM_WRITE_ADDRESS/MEM_WRITE_DATA
//   DUMP_REQ in, SHOW_EN out (held until reset)
//
// state    | meaning
// ---------+----------------------------------------------------------------
// ST_IDLE  | ready for a request or a dump request
// ST_READ  | memory read: capture load result or old word for RMW merge
// ST_WRITE | memory write of the full (possibly merged) word
// ST_RESP  | one-cycle response pulse
// ST_DUMP  | SHOW_EN held, no further requests until reset
// -----------------------------------------------------------------------------
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEFAULT
)
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WE,
  input  logic [1:0]  REQ_SIZE,
  input  logic        REQ_UNSIGNED,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  output logic        RSP_VALID,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_ERR,
  input  logic        DUMP_REQ,
  output logic        MEM_READ_EN,
  output logic        MEM_WRITE_EN,
  output logic [31:0] MEM_READ_ADDRESS,
  output logic [31:0] MEM_WRITE_ADDRESS,
  output logic [31:0] MEM_WRITE_DATA,
  input  logic [31:0] MEM_READ_DATA,
  output logic        SHOW_EN
);

  // One bit wider than the address so the full 32-bit range compares cleanly.
  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;

  state_t      state_q, state_d;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        we_q;
  logic        uns_q;
  logic [31:0] wdata_q;
  logic [31:0] word_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        accept;
  logic        req_err;
  logic [31:0] load_data;
  logic [31:0] merged_word;

  assign accept  = (state_q == ST_IDLE) && !DUMP_REQ && REQ_VALID;
  assign req_err = size_addr_bad(REQ_SIZE, REQ_ADDR[1:0]) ||
                   ({1'b0, REQ_ADDR} >= MEM_BYTES);

  mem_lane_align u_lane_align (
    .rd_word     (MEM_READ_DATA),
    .addr_lo     (addr_q[1:0]),
    .size        (size_q),
    .unsigned_ld (uns_q),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      word_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= REQ_ADDR;
        size_q  <= REQ_SIZE;
        we_q    <= REQ_WE;
        uns_q   <= REQ_UNSIGNED;
        wdata_q <= REQ_WDATA;
        // Word stores skip READ, so their write word is ready immediately.
        word_q  <= REQ_WDATA;
        err_q   <= req_err;
        rdata_q <= '0;
      end else if (state_q == ST_READ) begin
        if (we_q) word_q  <= merged_word;
        else      rdata_q <= load_data;
      end
    end
  end

  always_comb begin
    state_d           = state_q;
    REQ_READY         = 1'b0;
    RSP_VALID         = 1'b0;
    RSP_ERR           = 1'b0;
    RSP_RDATA         = '0;
    MEM_READ_EN       = 1'b0;
    MEM_WRITE_EN      = 1'b0;
    MEM_READ_ADDRESS  = '0;
    MEM_WRITE_ADDRESS = '0;
    MEM_WRITE_DATA    = '0;
    SHOW_EN           = 1'b0;

    case (state_q)
      ST_IDLE: begin
        REQ_READY = 1'b1;
        if (DUMP_REQ) begin
          state_d = ST_DUMP;
        end else if (REQ_VALID) begin
          if (req_err)                  state_d = ST_RESP;
          else if (!REQ_WE)             state_d = ST_READ;
          else if (REQ_SIZE == SIZE_WORD) state_d = ST_WRITE;
          else                          state_d = ST_READ;
        end
      end
      ST_READ: begin
        MEM_READ_EN      = 1'b1;
        MEM_READ_ADDRESS = {addr_q[31:2], 2'b00};
        state_d          = we_q ? ST_WRITE : ST_RESP;
      end
      ST_WRITE: begin
        MEM_WRITE_EN      = 1'b1;
        MEM_WRITE_ADDRESS = {addr_q[31:2], 2'b00};
        MEM_WRITE_DATA    = word_q;
        state_d           = ST_RESP;
      end
      ST_RESP: begin
        RSP_VALID = 1'b1;
        RSP_ERR   = err_q;
        RSP_RDATA = rdata_q;
        state_d   = ST_IDLE;
      end
      ST_DUMP: begin
        SHOW_EN = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_WE;
  logic [1:0]  REQ_SIZE;
  logic        REQ_UNSIGNED;
  logic [31:0] REQ_ADDR;
  logic [31:0] REQ_WDATA;
  logic        RSP_VALID;
  logic [31:0] RSP_RDATA;
  logic        RSP_ERR;
  logic        DUMP_REQ;
  logic        MEM_READ_EN;
  logic        MEM_WRITE_EN;
  logic [31:0] MEM_READ_ADDRESS;
  logic [31:0] MEM_WRITE_ADDRESS;
  logic [31:0] MEM_WRITE_DATA;
  logic [31:0] MEM_READ_DATA;
  logic        SHOW_EN;

  always #5 CLK = ~CLK;

  mem_access_ctrl #(.MEM_WORDS(512)) dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .REQ_VALID         (REQ_VALID),
    .REQ_READY         (REQ_READY),
    .REQ_WE            (REQ_WE),
    .REQ_SIZE          (REQ_SIZE),
    .REQ_UNSIGNED      (REQ_UNSIGNED),
    .REQ_ADDR          (REQ_ADDR),
    .REQ_WDATA         (REQ_WDATA),
    .RSP_VALID         (RSP_VALID),
    .RSP_RDATA         (RSP_RDATA),
    .RSP_ERR           (RSP_ERR),
    .DUMP_REQ          (DUMP_REQ),
    .MEM_READ_EN       (MEM_READ_EN),
    .MEM_WRITE_EN      (MEM_WRITE_EN),
    .MEM_READ_ADDRESS  (MEM_READ_ADDRESS),
    .MEM_WRITE_ADDRESS (MEM_WRITE_ADDRESS),
    .MEM_WRITE_DATA    (MEM_WRITE_DATA),
    .MEM_READ_DATA     (MEM_READ_DATA),
    .SHOW_EN           (SHOW_EN)
  );

  // Attached memory (what the DUT actually sees) and the reference byte image.
  logic [31:0] tb_mem    [0:511];
  logic [7:0]  ref_bytes [0:2047];

  assign MEM_READ_DATA = tb_mem[MEM_READ_ADDRESS[10:2]];

  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          rsp_cnt = 0;
  int          both_cnt = 0;
  int          bus_bad = 0;
  logic [31:0] last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;

  always @(posedge CLK) begin
    if (MEM_WRITE_EN) begin
      tb_mem[MEM_WRITE_ADDRESS[10:2]] <= MEM_WRITE_DATA;
      wr_cnt       = wr_cnt + 1;
      last_wr_addr = MEM_WRITE_ADDRESS;
      last_wr_data = MEM_WRITE_DATA;
    end
    if (MEM_READ_EN) rd_cnt = rd_cnt + 1;
    if (MEM_READ_EN && MEM_WRITE_EN) both_cnt = both_cnt + 1;
    if (RSP_VALID) rsp_cnt = rsp_cnt + 1;
    if (MEM_READ_EN  ? (MEM_READ_ADDRESS[1:0] != 2'b00)  : (MEM_READ_ADDRESS != 0))
      bus_bad = bus_bad + 1;
    if (MEM_WRITE_EN ? (MEM_WRITE_ADDRESS[1:0] != 2'b00) : (MEM_WRITE_ADDRESS != 0 || MEM_WRITE_DATA != 0))
      bus_bad = bus_bad + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Issue one request and compare the response against the byte-level model.
  task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
    logic        err;
    int          nbytes;
    int          exp_lat;
    logic [31:0] exp_rdata;
    logic [31:0] exp_word;
    logic [31:0] base;
    int          lat;
    logic [31:0] got_rdata;
    logic        got_err;
    int          w0, r0;

    err = (size == 2'd3) || (size == 2'd1 && addr[0]) ||
          (size == 2'd2 && addr[1:0] != 2'b00) || (addr >= 32'd2048);
    nbytes    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    exp_rdata = '0;
    exp_word  = '0;
    base      = {addr[31:2], 2'b00};
    if (err)              exp_lat = 1;
    else if (!we)         exp_lat = 2;
    else if (nbytes == 4) exp_lat = 2;
    else                  exp_lat = 3;

    if (!err && we) begin
      for (int i = 0; i < nbytes; i++) ref_bytes[addr + i] = wdata[8*i +: 8];
      for (int i = 0; i < 4; i++) exp_word[8*i +: 8] = ref_bytes[base + i];
    end
    if (!err && !we) begin
      for (int i = 0; i < nbytes; i++) exp_rdata[8*i +: 8] = ref_bytes[addr + i];
      if (!uns && nbytes == 1 && exp_rdata[7])  exp_rdata = exp_rdata | 32'hFFFF_FF00;
      if (!uns && nbytes == 2 && exp_rdata[15]) exp_rdata = exp_rdata | 32'hFFFF_0000;
    end

    @(negedge CLK);
    chk("ready_before_req", {31'd0, REQ_READY}, 32'd1);
    REQ_VALID    = 1'b1;
    REQ_WE       = we;
    REQ_SIZE     = size;
    REQ_UNSIGNED = uns;
    REQ_ADDR     = addr;
    REQ_WDATA    = wdata;
    w0 = wr_cnt;
    r0 = rd_cnt;
    @(posedge CLK);
    #1;
    // Scramble the request fields: the DUT must work from its registered copy.
    REQ_VALID    = 1'b0;
    REQ_WE       = 1'($urandom);
    REQ_SIZE     = 2'($urandom);
    REQ_UNSIGNED = 1'($urandom);
    REQ_ADDR     = $urandom;
    REQ_WDATA    = $urandom;

    lat       = 0;
    got_rdata = '0;
    got_err   = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge CLK);
      if (RSP_VALID) begin
        lat       = k;
        got_rdata = RSP_RDATA;
        got_err   = RSP_ERR;
        break;
      end
    end
    chk("rsp_latency", 32'(lat), 32'(exp_lat));
    chk("rsp_err",     {31'd0, got_err}, {31'd0, err});
    chk("rsp_rdata",   got_rdata, exp_rdata);
    chk("write_count", 32'(wr_cnt - w0), (we && !err) ? 32'd1 : 32'd0);
    chk("read_count",  32'(rd_cnt - r0), (!err && (!we || nbytes != 4)) ? 32'd1 : 32'd0);
    if (we && !err) begin
      chk("write_addr", last_wr_addr, base);
      chk("write_data", last_wr_data, exp_word);
    end
    @(negedge CLK);
    chk("rsp_one_cycle", {31'd0, RSP_VALID}, 32'd0);
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] a;
    logic [1:0]  sz;
    int          w0, r0;

    for (int i = 0; i < 512; i++) begin
      w = $urandom;
      tb_mem[i] = w;
      for (int k = 0; k < 4; k++) ref_bytes[4*i + k] = w[8*k +: 8];
    end

    RESET        = 1'b1;
    REQ_VALID    = 1'b0;
    REQ_WE       = 1'b0;
    REQ_SIZE     = 2'b00;
    REQ_UNSIGNED = 1'b0;
    REQ_ADDR     = '0;
    REQ_WDATA    = '0;
    DUMP_REQ     = 1'b0;
    repeat (3) @(negedge CLK);
    chk("reset_rsp_valid", {31'd0, RSP_VALID}, 32'd0);
    chk("reset_rsp_err",   {31'd0, RSP_ERR}, 32'd0);
    chk("reset_rsp_rdata", RSP_RDATA, 32'd0);
    chk("reset_strobes",   {30'd0, MEM_READ_EN, MEM_WRITE_EN}, 32'd0);
    chk("reset_show_en",   {31'd0, SHOW_EN}, 32'd0);
    RESET = 1'b0;
    @(negedge CLK);
    chk("ready_after_reset", {31'd0, REQ_READY}, 32'd1);

    // Word store then load.
    run_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
    chk("dir_word_wr_data", last_wr_data, 32'hDEAD_BEEF);
    run_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);

    // Byte RMW onto a known word.
    run_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h1122_3344);
    run_req(1'b1, 2'd0, 1'b0, 32'h13, 32'h0000_00AA);
    chk("dir_rmw_data", last_wr_data, 32'hAA22_3344);

    // Lane extraction with both extensions.
    run_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
    run_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
    run_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
    run_req(1'b0, 2'd1, 1'b1, 32'h10, 32'h0);

    // Error cases, including the first out-of-range address and size 11.
    run_req(1'b0, 2'd2, 1'b0, 32'h02, 32'h0);
    run_req(1'b1, 2'd1, 1'b0, 32'h05, 32'h1234);
    run_req(1'b1, 2'd2, 1'b0, 32'h800, 32'h5555_5555);
    run_req(1'b0, 2'd0, 1'b1, 32'h800, 32'h0);
    run_req(1'b1, 2'd3, 1'b0, 32'h20, 32'h77);
    run_req(1'b0, 2'd2, 1'b0, 32'h7FC, 32'h0);
    run_req(1'b1, 2'd0, 1'b0, 32'h7FF, 32'h00C3);

    // Random traffic concentrated on a small window to force overlaps.
    for (int n = 0; n < 300; n++) begin
      sz = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0:       a = 32'h7F8 + 32'($urandom_range(0, 15));
        1:       a = $urandom;
        default: a = 32'($urandom_range(0, 63));
      endcase
      if ($urandom_range(0, 1) == 1) begin
        if (sz == 2'd1) a[0]   = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      run_req(1'($urandom), sz, 1'($urandom), a, $urandom);
    end

    // Reset during the READ of a byte-store RMW.
    @(negedge CLK);
    REQ_VALID = 1'b1;
    REQ_WE    = 1'b1;
    REQ_SIZE  = 2'd0;
    REQ_ADDR  = 32'h21;
    REQ_WDATA = 32'h5A;
    @(posedge CLK);
    #1;
    REQ_VALID = 1'b0;
    @(negedge CLK);
    chk("rmw_in_read", {31'd0, MEM_READ_EN}, 32'd1);
    w0 = wr_cnt;
    r0 = rsp_cnt;
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    repeat (3) @(negedge CLK);
    chk("abort_no_write", 32'(wr_cnt - w0), 32'd0);
    chk("abort_no_rsp",   32'(rsp_cnt - r0), 32'd0);
    chk("abort_ready",    {31'd0, REQ_READY}, 32'd1);
    run_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);

    // Dump request wins over a simultaneous request.
    @(negedge CLK);
    w0 = wr_cnt;
    r0 = rsp_cnt;
    DUMP_REQ  = 1'b1;
    REQ_VALID = 1'b1;
    REQ_WE    = 1'b1;
    REQ_SIZE  = 2'd2;
    REQ_ADDR  = 32'h40;
    REQ_WDATA = 32'hCAFE_F00D;
    @(posedge CLK);
    #1;
    DUMP_REQ  = 1'b0;
    @(negedge CLK);
    chk("dump_show_en", {31'd0, SHOW_EN}, 32'd1);
    chk("dump_not_ready", {31'd0, REQ_READY}, 32'd0);
    repeat (4) @(negedge CLK);
    REQ_VALID = 1'b0;
    chk("dump_show_held", {31'd0, SHOW_EN}, 32'd1);
    chk("dump_no_write", 32'(wr_cnt - w0), 32'd0);
    chk("dump_no_rsp",   32'(rsp_cnt - r0), 32'd0);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    chk("dump_cleared", {31'd0, SHOW_EN}, 32'd0);
    chk("ready_after_dump_reset", {31'd0, REQ_READY}, 32'd1);

    chk("strobe_overlap", 32'(both_cnt), 32'd0);
    chk("bus_idle_values", 32'(bus_bad), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter MEM_WORDS, default 512: number of 32-bit words in the attached main memory.
REQ-002 CLK  input  1  single clock; all state updates on posedge.
REQ-003 RESET  input  1  asynchronous, active-high reset.
REQ-004 REQ_VALID  input  1  load/store request from the core.
REQ-005 REQ_READY  output  1  request accepted when REQ_VALID && REQ_READY at posedge.
REQ-006 REQ_WE  input  1  1 = store, 0 = load.
REQ-007 REQ_SIZE  input  2  00 byte, 01 half, 10 word; 11 is illegal.
REQ-008 REQ_UNSIGNED  input  1  loads: 1 = zero-extend, 0 = sign-extend.
REQ-009 REQ_ADDR  input  32  byte address.
REQ-010 REQ_WDATA  input  32  store data, right-aligned.
REQ-011 RSP_VALID  output  1  one-cycle completion pulse; no backpressure.
REQ-012 RSP_RDATA  output  32  load result, extended; 0 for stores and errors.
REQ-013 RSP_ERR  output  1  request was misaligned, out of range or illegal size.
REQ-014 DUMP_REQ  input  1  request a memory dump and end of simulation.
REQ-015 MEM_READ_EN, MEM_WRITE_EN  output  1 each  memory strobes.
REQ-016 MEM_READ_ADDRESS, MEM_WRITE_ADDRESS  output  32 each  word-aligned byte addresses (bits [1:0] = 00).
REQ-017 MEM_WRITE_DATA  output  32  full word written.
REQ-018 MEM_READ_DATA  input  32  combinational read data, valid in the same cycle as MEM_READ_EN.
REQ-019 SHOW_EN  output  1  memory dump trigger.

Function
REQ-020 FSM states: IDLE, READ, WRITE, RESP, DUMP; REQ_READY = 1 only in IDLE.
REQ-021 In IDLE, DUMP_REQ has priority over REQ_VALID; when DUMP_REQ is taken, the FSM enters DUMP and holds SHOW_EN = 1 until reset; REQ_READY = 0.
REQ-022 On acceptance, address, size, WE, UNSIGNED and WDATA are registered; later input changes are ignored.
REQ-023 Error conditions:
- REQ_SIZE = 11;
- half with ADDR[0] = 1;
- word with ADDR[1:0] != 00;
- ADDR >= 4*MEM_WORDS.
REQ-024 On an error request: go directly to RESP; RSP_VALID and RSP_ERR at cycle N+1 (N = accept cycle); no memory strobe is asserted.
REQ-025 Load: READ at N+1 (MEM_READ_EN = 1; lane extracted; result captured); RESP at N+2.
REQ-026 Word store: WRITE at N+1 (MEM_WRITE_EN = 1, data = WDATA); RESP at N+2.
REQ-027 Byte/half store (read-modify-write):
- READ at N+1 captures the old word;
- WRITE at N+2 writes the merged word;
- RESP at N+3.
REQ-028 Lane mapping is little-endian: byte k of the word = ADDR[1:0] = k; half at ADDR[1] selects bits [31:16].
REQ-029 Merge replaces only the addressed lane with the low 8/16 bits of WDATA; other lanes are unchanged.
REQ-030 RESP lasts exactly one cycle, then IDLE; earliest next acceptance is the cycle after RESP.
REQ-031 Both strobes are never high in the same cycle; at most one MEM_WRITE_EN cycle per store.
REQ-032 Outside READ/WRITE, strobes = 0 and memory address/data outputs = 0.

Reset
REQ-033 RESET asynchronously forces IDLE, clears all registered request fields, and sets outputs to: REQ_READY = 1 after deassertion, RSP_VALID = 0, RSP_ERR = 0, RSP_RDATA = 0, strobes = 0, SHOW_EN = 0.
REQ-034 Reset mid-operation (including between READ and WRITE of an RMW) aborts the operation: no write and no response are issued.

Structure
REQ-035 Shared package mem_pkg holds the state enum, REQ_SIZE encodings and MEM_WORDS default.
REQ-036 Sub-module mem_lane_align (combinational) holds lane extraction with sign/zero extension and lane merge.

Verification
REQ-037 Word store 0xDEADBEEF @0x10, then load word @0x10 -> one MEM_WRITE_EN at N+1, WRITE_ADDRESS = 0x10; load RSP_RDATA = 0xDEADBEEF at N+2.
REQ-038 Byte store 0xAA @0x13 onto 0x11223344 -> READ at N+1, write 0xAA223344 at N+2, RSP_VALID at N+3.
REQ-039 Load byte @0x13 signed -> 0xFFFFFFAA; unsigned -> 0x000000AA; load half @0x12 signed -> 0xFFFFAA22.
REQ-040 Errors: word @0x02, half @0x05, any access @0x800 -> RSP_ERR = 1 at N+1, no strobes.
REQ-041 RESET asserted during READ of an RMW byte store -> no MEM_WRITE_EN, no RSP_VALID, REQ_READY = 1 after release.
REQ-042 DUMP_REQ and REQ_VALID together in IDLE -> SHOW_EN = 1 from the next cycle onward, request not accepted.
